// File: rtl/ars_mult_arb_pkg.sv
// Shared constants for the GF(2^233) multiplier arbiter: FSM encoding,
// field width, default watchdog limit and the round-robin pointer step.
package ars_mult_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  localparam int FIELD_W    = 233;
  localparam int TO_CYC_DEF = 4096;

  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ars_rr_picker.sv
// Combinational round-robin select: first set req bit at or after ptr,
// wrapping modulo NREQ.
module ars_rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  always_comb begin
    int pos;
    winner = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = 0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (req[pos]) begin
        idx   = IW'(pos);
        valid = 1'b1;
      end
    end
    if (valid) winner[idx] = 1'b1;
  end

endmodule

// File: rtl/ars_mult_arbiter.sv
// Round-robin arbiter sharing one GF(2^233) multiplier between NREQ requesters.
// Optional watchdog abort enabled by defining ARS_MULT_ARB_WATCHDOG_EN.
module ars_mult_arbiter
  import ars_mult_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int W      = FIELD_W,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic              clk,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      res,
  output logic              err,
  output logic              busy,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic              mul_enb,
  input  logic              mul_rdy,
  input  logic [W-1:0]      mul_res
);

  localparam int IW = $clog2(NREQ);

  // Handshake: a requester holds req until it sees its gnt bit; the multiplier
  // job runs while mul_enb=1 and completes on the first mul_rdy=1; mul_enb then
  // drops and the arbiter waits in REL until mul_rdy falls before the next grant.

  logic [1:0]      state;
  logic [IW-1:0]   rr_ptr;
  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_vld;
  logic            wd_hit;

  ars_rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (win_oh),
    .idx    (win_idx),
    .valid  (win_vld)
  );

`ifdef ARS_MULT_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;

  // Held at zero outside RUN, so it is cleared on every entry to RUN.
  always_ff @(posedge clk) begin
    if (!en) begin
      wd_cnt <= '0;
    end else if (state != ST_RUN) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign wd_hit = (wd_cnt == 16'(TO_CYC - 1));
`else
  // No watchdog: the limit is never reached, RUN waits for mul_rdy forever.
  assign wd_hit = (TO_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (!en) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      done    <= '0;
      res     <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      mul_enb <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      rr_ptr  <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            gnt     <= win_oh;
            mul_a   <= op_a[win_idx*W +: W];
            mul_b   <= op_b[win_idx*W +: W];
            mul_enb <= 1'b1;
            rr_ptr  <= IW'(rr_next(int'(win_idx), NREQ));
            busy    <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Completion takes precedence over a watchdog hit on the same cycle.
          if (mul_rdy) begin
            res     <= mul_res;
            done    <= gnt;
            gnt     <= '0;
            mul_enb <= 1'b0;
            state   <= ST_REL;
          end else if (wd_hit) begin
            res     <= '0;
            done    <= gnt;
            err     <= 1'b1;
            gnt     <= '0;
            mul_enb <= 1'b0;
            state   <= ST_REL;
          end
        end
        ST_REL: begin
          if (!mul_rdy) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          gnt     <= '0;
          mul_enb <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ars_mult_arbiter.sv
// Bench for ars_mult_arbiter: behavioural GF(2^233) multiplier model,
// table-driven single jobs, fairness, release, reset and watchdog sequences.
module tb_ars_mult_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 233;

  logic              clk = 1'b0;
  logic              en;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_a, op_b;
  logic [NREQ-1:0]   gnt, done;
  logic [W-1:0]      res, mul_a, mul_b, mul_res;
  logic              err, busy, mul_enb, mul_rdy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  int           exp_idx_q[$];
  logic         exp_err_q[$];

  int lat_cfg  = 5;
  int hold_cfg = 0;
  int m_cnt, hold_left;
  logic [NREQ-1:0] prev_done = '0;

  ars_mult_arbiter #(.NREQ(NREQ), .W(W), .TO_CYC(16)) dut (
    .clk     (clk),
    .en      (en),
    .req     (req),
    .op_a    (op_a),
    .op_b    (op_b),
    .gnt     (gnt),
    .done    (done),
    .res     (res),
    .err     (err),
    .busy    (busy),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_enb (mul_enb),
    .mul_rdy (mul_rdy),
    .mul_res (mul_res)
  );

  always #5 clk = ~clk;

  // GF(2^233) product modulo x^233 + x^74 + 1.
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] acc;
    logic [W-1:0] sh;
    logic         carry;
    acc = '0;
    sh  = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) acc = acc ^ sh;
      carry = sh[W-1];
      sh = sh << 1;
      if (carry) begin
        sh[0]  = ~sh[0];
        sh[74] = ~sh[74];
      end
    end
    return acc;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  // Multiplier model: ready lat_cfg cycles into a job (0 = never), keeps
  // ready for hold_cfg extra cycles after enb drops.
  always @(posedge clk) begin
    if (!en) begin
      m_cnt     <= 0;
      hold_left <= 0;
      mul_rdy   <= 1'b0;
      mul_res   <= '0;
    end else if (mul_enb) begin
      hold_left <= hold_cfg;
      if (!mul_rdy && lat_cfg != 0) begin
        if (m_cnt + 1 >= lat_cfg) begin
          mul_rdy <= 1'b1;
          mul_res <= gf_mul(mul_a, mul_b);
        end
        m_cnt <= m_cnt + 1;
      end
    end else begin
      m_cnt <= 0;
      if (hold_left != 0) hold_left <= hold_left - 1;
      else mul_rdy <= 1'b0;
    end
  end

  // Scoreboard: every done pulse pops one expected completion.
  always @(negedge clk) begin
    if (done != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", W'(done), W'(0));
      end else begin
        check("done_vec", W'(done), W'(1 << exp_idx_q.pop_front()));
        check("res", res, exp_q.pop_front());
        check("err", W'(err), W'(exp_err_q.pop_front()));
        check("done_one_cycle", W'(done & prev_done), W'(0));
        check("done_gnt_overlap", W'(done & gnt), W'(0));
        check("done_not_idle", W'(busy), W'(1));
      end
    end
    prev_done = done;
  end

  task automatic wait_grant(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (gnt == '0 && cyc < 40);
  endtask

  task automatic scramble_ops();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i*W +: W] = W'({$urandom, $urandom});
      op_b[i*W +: W] = W'({$urandom, $urandom});
    end
  endtask

  // One job from IDLE; next_req is driven right after the grant.
  task automatic run_job(input logic [NREQ-1:0] rv, input int idx, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] e_res, input int lat,
                         input int hold, input logic [NREQ-1:0] next_req);
    int cyc;
    logic gnt_in_rel;
    lat_cfg  = lat;
    hold_cfg = hold;
    scramble_ops();
    op_a[idx*W +: W] = a;
    op_b[idx*W +: W] = b;
    req = rv;
    wait_grant(cyc);
    check("grant_latency", W'(cyc), W'(1));
    check("gnt_vec", W'(gnt), W'(1 << idx));
    check("mul_a", mul_a, a);
    check("mul_b", mul_b, b);
    check("mul_enb", W'(mul_enb), W'(1));
    exp_q.push_back(e_res);
    exp_idx_q.push_back(idx);
    exp_err_q.push_back(1'b0);
    req = next_req;
    scramble_ops();
    cyc = 0;
    while (done == '0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", W'(done != '0), W'(1));
    cyc = 0;
    gnt_in_rel = 1'b0;
    while (busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0 && busy) gnt_in_rel = 1'b1;
    end
    check("release_gap", W'(cyc), W'(2 + hold));
    check("no_grant_in_rel", W'(gnt_in_rel), W'(0));
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    int              idx;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [W-1:0]    e_res;
    int              lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cyc;
    logic [W-1:0] t, e, a, b;

    // Pointer walk: 0 ->1 ->2 ->1 ->0 ->3 ->1 ->3 ->0.
    vecs[0] = '{4'b0001, 0, W'(2),  W'(3),  W'(6),    10};
    vecs[1] = '{4'b0011, 1, W'(3),  W'(3),  W'(5),    4};
    vecs[2] = '{4'b0011, 0, W'(7),  W'(5),  W'('h1b), 3};
    vecs[3] = '{4'b1000, 3, W'(15), W'(15), W'('h55), 6};
    t = '0; t[W-1] = 1'b1;
    e = '0; e[74] = 1'b1; e[0] = 1'b1;
    vecs[4] = '{4'b1100, 2, t, W'(2), e, 2};
    for (int i = 5; i < 8; i++) begin
      a = W'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      b = W'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      vecs[i] = '{4'b0101, 0, a, b, gf_mul(a, b), $urandom_range(1, 8)};
    end
    vecs[6].idx = 2;
    vecs[7].req = 4'b1111;
    vecs[7].idx = 3;
    vecs[7].lat = 1;

    en = 1'b0;
    req = '0;
    op_a = '0;
    op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", W'(gnt), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_enb", W'(mul_enb), W'(0));
    check("rst_res", res, W'(0));
    en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_job(vecs[i].req, vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].e_res, vecs[i].lat, 0, '0);

    // Fairness: all requesters held for 8 jobs, pointer starts at 0.
    hold_cfg = 0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i*W +: W] = W'(i + 2);
      op_b[i*W +: W] = W'(i + 5);
    end
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      lat_cfg = $urandom_range(1, 6);
      cyc = 0;
      while (gnt == '0 && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check("fair_gnt", W'(gnt), W'(1 << (k % NREQ)));
      exp_q.push_back(gf_mul(W'((k % NREQ) + 2), W'((k % NREQ) + 5)));
      exp_idx_q.push_back(k % NREQ);
      exp_err_q.push_back(1'b0);
      cyc = 0;
      while (gnt != '0 && cyc < 400) begin
        @(negedge clk);
        cyc++;
      end
    end
    req = '0;
    cyc = 0;
    while (busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("fair_idle", W'(busy), W'(0));

    // Release: ready held 3 cycles past enb drop, next request waiting.
    a = W'(9); b = W'(6);
    run_job(4'b0010, 1, a, b, gf_mul(a, b), 5, 3, 4'b0100);
    a = W'(11); b = W'(13);
    run_job(4'b0100, 2, a, b, gf_mul(a, b), 2, 0, '0);

    // Reset in RUN cycle 5 with pointer at 1 after this grant.
    lat_cfg = 0;
    req = 4'b0001;
    wait_grant(cyc);
    check("rst_job_gnt", W'(gnt), W'(1));
    req = '0;
    repeat (4) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("midrst_enb", W'(mul_enb), W'(0));
    check("midrst_gnt", W'(gnt), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_res", res, W'(0));
    check("midrst_mul_a", mul_a, W'(0));
    en = 1'b1;
    @(negedge clk);
    a = W'(21); b = W'(17);
    run_job(4'b0011, 0, a, b, gf_mul(a, b), 3, 0, '0);

    // Multiplier never readies.
    lat_cfg = 0;
    req = 4'b0010;
    wait_grant(cyc);
    check("wd_gnt", W'(gnt), W'(2));
    req = '0;
`ifdef ARS_MULT_ARB_WATCHDOG_EN
    exp_q.push_back(W'(0));
    exp_idx_q.push_back(1);
    exp_err_q.push_back(1'b1);
    cyc = 0;
    while (done == '0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("wd_abort_cycle", W'(cyc), W'(16));
    repeat (3) @(negedge clk);
    check("wd_idle", W'(busy), W'(0));
`else
    repeat (40) @(negedge clk);
    check("wd_off_busy", W'(busy), W'(1));
    check("wd_off_gnt", W'(gnt), W'(2));
`endif
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("scoreboard_drained", W'(exp_q.size()), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
